// File: rtl/id_ex_if.sv
// Decode-to-execute pipeline bus: decode-side fields in, execute-side registered fields out.
// master drives the decode slot and flush; slave is the ID/EX register stage.
interface id_ex_if;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [31:0] id_imm;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic [3:0]  id_funct;
   logic [2:0]  id_exCtrl;
   logic [2:0]  id_memCtrl;
   logic [1:0]  id_wbCtrl;
   logic        ex_flush;

   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs1_data;
   logic [31:0] ex_rs2_data;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [4:0]  ex_rd;
   logic [3:0]  ex_funct;
   logic [2:0]  ex_exCtrl;
   logic [2:0]  ex_memCtrl;
   logic [1:0]  ex_wbCtrl;
   logic        hazard_stall;
   logic [15:0] bubble_count;

   modport master (
      output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_funct, id_exCtrl, id_memCtrl, id_wbCtrl,
             ex_flush,
      input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_funct, ex_exCtrl, ex_memCtrl, ex_wbCtrl,
             hazard_stall, bubble_count
   );

   modport slave (
      input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_funct, id_exCtrl, id_memCtrl, id_wbCtrl,
             ex_flush,
      output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_funct, ex_exCtrl, ex_memCtrl, ex_wbCtrl,
             hazard_stall, bubble_count
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and flush.
// Each edge applies one action by priority FLUSH > BUBBLE > CAPTURE; bubble_count saturates.
module id_ex_stage (
   input logic     clk,
   input logic     rst_n,
   id_ex_if.slave  bus
);

   typedef enum logic [1:0] {
      ACT_CAPTURE = 2'd0,
      ACT_BUBBLE  = 2'd1,
      ACT_FLUSH   = 2'd2
   } action_t;

   logic        r_valid;
   logic [31:0] r_pc;
   logic [31:0] r_rs1_data;
   logic [31:0] r_rs2_data;
   logic [31:0] r_imm;
   logic [4:0]  r_rs1;
   logic [4:0]  r_rs2;
   logic [4:0]  r_rd;
   logic [3:0]  r_funct;
   logic [2:0]  r_exCtrl;
   logic [2:0]  r_memCtrl;
   logic [1:0]  r_wbCtrl;
   logic [15:0] r_bubble_count;

   logic        w_hazard_stall;
   action_t     w_action;
   logic [2:0]  w_cap_exCtrl;
   logic [2:0]  w_cap_memCtrl;
   logic [1:0]  w_cap_wbCtrl;
   logic [15:0] w_bubble_inc;

   // Load in EX whose destination feeds the decode slot; rs2 compared even if unused
   always_comb begin
      w_hazard_stall = r_valid & r_memCtrl[2] & (r_rd != 5'd0) & bus.id_valid &
                       ((r_rd == bus.id_rs1) | (r_rd == bus.id_rs2));
   end

   // Action select and captured control gating
   always_comb begin
      w_action      = ACT_CAPTURE;
      w_cap_exCtrl  = 3'b000;
      w_cap_memCtrl = 3'b000;
      w_cap_wbCtrl  = 2'b00;
      if (bus.ex_flush) begin
         w_action = ACT_FLUSH;
      end else if (w_hazard_stall) begin
         w_action = ACT_BUBBLE;
      end else begin
         w_action = ACT_CAPTURE;
      end
      if (bus.id_valid) begin
         w_cap_exCtrl  = bus.id_exCtrl;
         w_cap_memCtrl = bus.id_memCtrl;
         w_cap_wbCtrl  = bus.id_wbCtrl;
      end else begin
         w_cap_exCtrl  = 3'b000;
         w_cap_memCtrl = 3'b000;
         w_cap_wbCtrl  = 2'b00;
      end
   end

   // Saturating bubble counter increment
   always_comb begin
      if (r_bubble_count == 16'hFFFF) begin
         w_bubble_inc = r_bubble_count;
      end else begin
         w_bubble_inc = r_bubble_count + 16'd1;
      end
   end

   // Pipeline register state update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid        <= 1'b0;
         r_pc           <= 32'd0;
         r_rs1_data     <= 32'd0;
         r_rs2_data     <= 32'd0;
         r_imm          <= 32'd0;
         r_rs1          <= 5'd0;
         r_rs2          <= 5'd0;
         r_rd           <= 5'd0;
         r_funct        <= 4'd0;
         r_exCtrl       <= 3'd0;
         r_memCtrl      <= 3'd0;
         r_wbCtrl       <= 2'd0;
         r_bubble_count <= 16'd0;
      end else begin
         case (w_action)
            ACT_CAPTURE: begin
               r_valid    <= bus.id_valid;
               r_pc       <= bus.id_pc;
               r_rs1_data <= bus.id_rs1_data;
               r_rs2_data <= bus.id_rs2_data;
               r_imm      <= bus.id_imm;
               r_rs1      <= bus.id_rs1;
               r_rs2      <= bus.id_rs2;
               r_rd       <= bus.id_rd;
               r_funct    <= bus.id_funct;
               r_exCtrl   <= w_cap_exCtrl;
               r_memCtrl  <= w_cap_memCtrl;
               r_wbCtrl   <= w_cap_wbCtrl;
            end
            ACT_BUBBLE: begin
               r_valid        <= 1'b0;
               r_exCtrl       <= 3'd0;
               r_memCtrl      <= 3'd0;
               r_wbCtrl       <= 2'd0;
               r_bubble_count <= w_bubble_inc;
            end
            ACT_FLUSH: begin
               r_valid   <= 1'b0;
               r_exCtrl  <= 3'd0;
               r_memCtrl <= 3'd0;
               r_wbCtrl  <= 2'd0;
            end
            default: begin
               // Unreachable encoding: fall back to a safe invalid slot
               r_valid   <= 1'b0;
               r_exCtrl  <= 3'd0;
               r_memCtrl <= 3'd0;
               r_wbCtrl  <= 2'd0;
            end
         endcase
      end
   end

   assign bus.ex_valid     = r_valid;
   assign bus.ex_pc        = r_pc;
   assign bus.ex_rs1_data  = r_rs1_data;
   assign bus.ex_rs2_data  = r_rs2_data;
   assign bus.ex_imm       = r_imm;
   assign bus.ex_rs1       = r_rs1;
   assign bus.ex_rs2       = r_rs2;
   assign bus.ex_rd        = r_rd;
   assign bus.ex_funct     = r_funct;
   assign bus.ex_exCtrl    = r_exCtrl;
   assign bus.ex_memCtrl   = r_memCtrl;
   assign bus.ex_wbCtrl    = r_wbCtrl;
   assign bus.bubble_count = r_bubble_count;
   assign bus.hazard_stall = w_hazard_stall;

endmodule
